// File: rtl/dffram_clr.sv
// rtl/dffram_clr.sv - byte-writable single-port DFF RAM with zero-idle output and hardware clear sweep
module dffram_clr #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 512,
    parameter int WRITE_FIRST = 0,
    parameter int A_WIDTH     = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN0,
    input  logic [WIDTH/8-1:0]   WE0,
    input  logic [A_WIDTH-1:0]   A0,
    input  logic [WIDTH-1:0]     Di0,
    output logic [WIDTH-1:0]     Do0,
    input  logic                 CLR,
    output logic                 BUSY
);

    localparam int NB = WIDTH / 8;
    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   ccnt_q, ccnt_d;
    logic [WIDTH-1:0]     do_q, do_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic                 sweep_wr;
    logic                 user_acc;
    logic [WIDTH-1:0]     rd_word;
    logic [WIDTH-1:0]     merged;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_CLEAR;
            ccnt_q  <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            do_q    <= do_d;
        end
    end

    // A CLR seen during the sweep restarts it: that edge writes nothing and reloads ccnt.
    always_comb begin
        state_d = state_q;
        ccnt_d  = '0;
        case (state_q)
            S_CLEAR: begin
                if (!CLR) begin
                    if (ccnt_q == LAST) state_d = S_IDLE;
                    else                ccnt_d  = ccnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (CLR) state_d = S_CLEAR;
            end
        endcase
    end

    always_comb begin
        sweep_wr = (state_q == S_CLEAR) && !CLR;
        user_acc = (state_q == S_IDLE) && !CLR && EN0;
        rd_word  = mem_q[A0];
        merged   = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (WE0[i]) merged[8*i +: 8] = Di0[8*i +: 8];
        end
        do_d = '0;
        if (user_acc) do_d = (WRITE_FIRST != 0) ? merged : rd_word;
    end

    // Contents are deliberately not reset; the sweep is what zeroes them.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (sweep_wr)      mem_q[ccnt_q] <= '0;
            else if (user_acc) mem_q[A0]     <= merged;
        end
    end

    assign Do0  = do_q;
    assign BUSY = (state_q == S_CLEAR);

endmodule

// File: tb/tb_dffram_clr.sv
// tb/tb_dffram_clr.sv - scoreboard bench for dffram_clr (default/read-first and 16x8/write-first)
module tb_dffram_clr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        en    [2];
    logic [3:0]  we    [2];
    logic [8:0]  a     [2];
    logic [31:0] di    [2];
    logic        clr   [2];
    logic        busy  [2];
    logic        iss   [2];
    logic [31:0] do0;
    logic [15:0] do1;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          t0 [$];
    int          t1 [$];

    dffram_clr u_dut0 (
        .CLK(clk), .RST_N(rst_n[0]), .EN0(en[0]), .WE0(we[0]), .A0(a[0]),
        .Di0(di[0]), .Do0(do0), .CLR(clr[0]), .BUSY(busy[0])
    );

    dffram_clr #(.WIDTH(16), .DEPTH(8), .WRITE_FIRST(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n[1]), .EN0(en[1]), .WE0(we[1][1:0]), .A0(a[1][2:0]),
        .Di0(di[1][15:0]), .Do0(do1), .CLR(clr[1]), .BUSY(busy[1])
    );

    function automatic logic [31:0] get_do(input int d);
        return (d == 0) ? do0 : {16'h0, do1};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic pop_cmp(input int d);
        logic [31:0] ex;
        int tg;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected output: got %h expected nothing", d, get_do(d));
            return;
        end
        if (d == 0) begin ex = q0.pop_front(); tg = t0.pop_front(); end
        else        begin ex = q1.pop_front(); tg = t1.pop_front(); end
        check($sformatf("dut%0d read #%0d", d, tg), get_do(d), ex);
    endtask

    initial forever begin
        @(posedge clk);
        if (iss[0]) begin #1; pop_cmp(0); end
    end

    initial forever begin
        @(posedge clk);
        if (iss[1]) begin #1; pop_cmp(1); end
    end

    // One cycle of stimulus, entered and left at a falling edge.
    task automatic drv(input int d, input bit e, input logic [3:0] w, input logic [8:0] ad,
                       input logic [31:0] dat, input bit c, input bit chk, input logic [31:0] ex);
        en[d] = e; we[d] = w; a[d] = ad; di[d] = dat; clr[d] = c; iss[d] = chk;
        if (chk) begin
            if (d == 0) begin q0.push_back(ex); t0.push_back(seq); end
            else        begin q1.push_back(ex); t1.push_back(seq); end
            seq++;
        end
        @(negedge clk);
        en[d] = 1'b0; we[d] = '0; clr[d] = 1'b0; iss[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [8:0] ad, input logic [31:0] ex);
        drv(d, 1'b1, 4'h0, ad, 32'h0, 1'b0, 1'b1, ex);
    endtask

    task automatic wr(input int d, input logic [3:0] w, input logic [8:0] ad,
                      input logic [31:0] dat, input logic [31:0] ex);
        drv(d, 1'b1, w, ad, dat, 1'b0, 1'b1, ex);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) drv(d, 1'b0, 4'h0, 9'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pulse_clr(input int d);
        drv(d, 1'b0, 4'h0, 9'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    // Counts cycles with BUSY high; optional pokes are write-reads that must be ignored.
    task automatic busy_len(input int d, input bit poke, input int exp_n, input string nm);
        int n = 0;
        while (busy[d] && n < 4096) begin
            drv(d, poke, poke ? 4'hF : 4'h0, 9'(n), 32'hFFFF_FFFF, 1'b0, poke, 32'h0);
            n++;
        end
        check(nm, 32'(n), 32'(exp_n));
    endtask

    task automatic rst_pulse(input int d, input string nm);
        rst_n[d] = 1'b0;
        #1;
        check({nm, " busy in reset"}, 32'(busy[d]), 32'h1);
        check({nm, " dout in reset"}, get_do(d), 32'h0);
        @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; en[d] = 1'b0; we[d] = '0; a[d] = '0;
            di[d] = '0; clr[d] = 1'b0; iss[d] = 1'b0;
        end
        repeat (2) @(negedge clk);

        rst_pulse(0, "dut0 por");
        busy_len(0, 1'b0, 512, "dut0 busy after reset");
        rd(0, 9'd0, 32'h0);
        rd(0, 9'd255, 32'h0);
        rd(0, 9'd511, 32'h0);

        wr(0, 4'hF, 9'd5, 32'hDEAD_BEEF, 32'h0);
        rd(0, 9'd5, 32'hDEAD_BEEF);
        wr(0, 4'h2, 9'd5, 32'h0000_AA00, 32'hDEAD_BEEF);
        rd(0, 9'd5, 32'hDEAD_AAEF);

        wr(0, 4'hF, 9'd7, 32'h1111_1111, 32'h0);
        wr(0, 4'hF, 9'd7, 32'h2222_2222, 32'h1111_1111);
        rd(0, 9'd7, 32'h2222_2222);

        wr(0, 4'hF, 9'd3, 32'h3333_3333, 32'h0);
        drv(0, 1'b0, 4'hF, 9'd3, 32'h1234_5678, 1'b0, 1'b1, 32'h0);
        rd(0, 9'd3, 32'h3333_3333);

        for (int i = 0; i < 512; i++)
            drv(0, 1'b1, 4'hF, 9'(i), 32'hA500_0000 | 32'(i), 1'b0, 1'b0, 32'h0);
        rd(0, 9'd9, 32'hA500_0009);
        rd(0, 9'd500, 32'hA500_01F4);
        drv(0, 1'b1, 4'hF, 9'd9, 32'h0, 1'b1, 1'b1, 32'h0);
        busy_len(0, 1'b1, 512, "dut0 busy after clr");
        for (int i = 0; i < 512; i++) rd(0, 9'(i), 32'h0);

        pulse_clr(0);
        idle(0, 50);
        pulse_clr(0);
        busy_len(0, 1'b0, 512, "dut0 busy after clr restart");

        pulse_clr(0);
        idle(0, 100);
        rst_pulse(0, "dut0 reset mid-sweep");
        busy_len(0, 1'b0, 512, "dut0 busy after mid-sweep reset");

        wr(0, 4'hF, 9'd20, 32'hCAFE_F00D, 32'h0);
        rd(0, 9'd20, 32'hCAFE_F00D);
        rst_pulse(0, "dut0 reset mid-access");
        busy_len(0, 1'b0, 512, "dut0 busy after mid-access reset");
        rd(0, 9'd20, 32'h0);

        rst_pulse(1, "dut1 por");
        busy_len(1, 1'b0, 8, "dut1 busy after reset");
        for (int i = 0; i < 8; i++) rd(1, 9'(i), 32'h0);
        wr(1, 4'h3, 9'd5, 32'h0000_BEEF, 32'h0000_BEEF);
        rd(1, 9'd5, 32'h0000_BEEF);
        wr(1, 4'h2, 9'd5, 32'h0000_AA00, 32'h0000_AAEF);
        rd(1, 9'd5, 32'h0000_AAEF);
        wr(1, 4'h3, 9'd7, 32'h0000_1111, 32'h0000_1111);
        wr(1, 4'h3, 9'd7, 32'h0000_2222, 32'h0000_2222);
        rd(1, 9'd7, 32'h0000_2222);
        wr(1, 4'h3, 9'd3, 32'h0000_3333, 32'h0000_3333);
        drv(1, 1'b0, 4'h3, 9'd3, 32'h0000_1234, 1'b0, 1'b1, 32'h0);
        wr(1, 4'h1, 9'd3, 32'h0000_00CC, 32'h0000_33CC);
        rd(1, 9'd3, 32'h0000_33CC);
        drv(1, 1'b1, 4'h3, 9'd5, 32'h0000_5555, 1'b1, 1'b1, 32'h0);
        busy_len(1, 1'b1, 8, "dut1 busy after clr");
        for (int i = 0; i < 8; i++) rd(1, 9'(i), 32'h0);
        pulse_clr(1);
        idle(1, 3);
        rst_pulse(1, "dut1 reset mid-sweep");
        busy_len(1, 1'b0, 8, "dut1 busy after mid-sweep reset");
        rd(1, 9'd7, 32'h0);

        idle(0, 2);
        check("dut0 scoreboard drained", 32'(q0.size()), 32'h0);
        check("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
